bcd_conv_arbiter: RTL and testbench
===================================

Name: bcd_conv_arbiter

Overview:
- Shares one combinational `binary_to_bcd` converter (5-bit binary in, 8-bit packed two-digit BCD out) among NUM_REQ requesters.
- Round-robin arbitration, valid/ready handshakes on every requester port and on the single response port.
- Response carries the requester ID.
- A saturating conversion counter provides status.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2..8.
- ID_W, 2, requester ID width; must equal log2(NUM_REQ).
- BIN_W, 5, binary operand width; fixed by the converter.
- BCD_W, 8, BCD result width; two packed digits, tens in [7:4], units in [3:0].
- CNT_W, 16, width of the conversion counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_data  in  NUM_REQ*BIN_W  operands; requester i occupies bits [i*BIN_W +: BIN_W].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_bcd  out  BCD_W  BCD result.
- busy  out  1  high whenever FSM is not IDLE.
- conv_count  out  CNT_W  completed responses; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release) clears:
  - FSM to IDLE.
  - rr_ptr = 0.
  - Operand, ID and result registers = 0.
  - rsp_valid = 0, busy = 0, conv_count = 0.
  - req_ready = 0 follows combinationally.
- Reset mid-operation: any in-flight conversion is discarded silently, with no response. No requester is considered accepted unless its handshake completed before reset.
- FSM states: IDLE, CONV, RESP.
- IDLE:
  - The grant is the first requester with req_valid=1, searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
  - req_ready[g]=1 combinationally for that requester only, in the same cycle. This is legal: ready depends on valid; valid never depends on ready.
  - On handshake: latch req_data slice g into the operand register and g into the ID register, set rr_ptr = g+1 (wraps to 0), go to CONV.
  - No valid requester: stay in IDLE, rr_ptr unchanged.
- CONV:
  - Register the converter output of the operand into rsp_bcd.
  - Set rsp_valid=1, go to RESP.
  - All req_ready=0.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_bcd stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: clear rsp_valid, increment conv_count (hold if all-ones), go to IDLE.
  - All req_ready=0.
- Latency: request handshake in cycle N gives rsp_valid in cycle N+2. Peak throughput is one conversion per 3 cycles with rsp_ready tied high.
- Requesters must hold req_valid and req_data stable until their handshake. Deasserting req_valid before grant is tolerated and simply not granted.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester with valid held continuously is served within NUM_REQ grants.
- Arithmetic: operand 0..31 maps to tens = operand/10 and units = operand%10. Results are always legal BCD (0x00..0x31), so there is no overflow case.
- busy = (state != IDLE).

Decomposition:
- Shared package `bcd_pkg` holds:
  - BIN_W and BCD_W constants.
  - FSM state enum {IDLE, CONV, RESP}.
  - Function next_rr(ptr, valid) returning the grant index.
- Sub-module: instantiate the existing `binary_to_bcd` (ports binary_input, bcd_output) as the shared datapath.
- Round-robin pick is an in-module function; no separate arbiter module.

Test Plan:
- Single request: req 1 sends 5'b10101 with rsp_ready=1 → req_ready[1] in the same cycle; two cycles later rsp_valid=1, rsp_id=1, rsp_bcd=8'h21; conv_count=1.
- Range sweep: operands 0..31 on req 0 → rsp_bcd = 8'h00..8'h31, each correct. Also explicitly 0 → 8'h00 and 31 → 8'h31.
- Fairness: all 4 requesters valid continuously with data 3, 9, 17, 30 → grant order 0, 1, 2, 3, 0 with rsp_bcd 8'h03, 8'h09, 8'h17, 8'h30; no requester granted twice before the others.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid/rsp_id/rsp_bcd stable, all req_ready=0, conv_count unchanged; it increments exactly once when rsp_ready=1.
- Reset mid-operation: assert rst_n=0 asynchronously while in CONV → same-instant rsp_valid=0, busy=0, conv_count=0; after release the next grant goes to requester 0 (rr_ptr=0).
- Counter saturation: with CNT_W=2, run 5 conversions → conv_count stays at 2'b11 after the third.

Source files
------------

// File: rtl/bcd_conv_arbiter_pkg.sv
// Purpose: shared widths, FSM state type and round-robin helper for the BCD conversion arbiter.
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package bcd_pkg;

    localparam int BIN_W   = 5;   // binary operand width accepted by the converter
    localparam int BCD_W   = 8;   // two packed BCD digits: tens [7:4], units [3:0]
    localparam int MAX_REQ = 8;   // widest requester vector next_rr can search

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

    // First set bit of valid searching ptr, ptr+1, ... modulo n.
    // Returns 0 when nothing is valid; callers qualify with |valid.
    function automatic logic [2:0] next_rr(input logic [2:0]         ptr,
                                           input logic [MAX_REQ-1:0] valid,
                                           input int                 n);
        logic [2:0] g;
        logic       found;
        int         idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && valid[idx]) begin
                g     = 3'(idx);
                found = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/bcd_conv_arbiter_binary_to_bcd.sv
// Purpose: combinational 5-bit binary to two-digit packed BCD converter.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: binary_input (0..31), bcd_output ({tens, units}).
module binary_to_bcd
    import bcd_pkg::*;
(
    input  logic [BIN_W-1:0] binary_input,
    output logic [BCD_W-1:0] bcd_output
);

    logic [3:0] tens;
    logic [3:0] units;

    // Operand never exceeds 31, so a three-step compare/subtract covers every tens digit.
    always_comb begin
        tens  = 4'd0;
        units = 4'(binary_input);
        if (binary_input >= 5'd30) begin
            tens  = 4'd3;
            units = 4'(binary_input - 5'd30);
        end else if (binary_input >= 5'd20) begin
            tens  = 4'd2;
            units = 4'(binary_input - 5'd20);
        end else if (binary_input >= 5'd10) begin
            tens  = 4'd1;
            units = 4'(binary_input - 5'd10);
        end
    end

    assign bcd_output = {tens, units};

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Purpose: round-robin shares one binary_to_bcd converter among NUM_REQ valid/ready requesters.
// Latency: request handshake in cycle N -> rsp_valid in cycle N+2; one conversion per 3 cycles peak.
// Backpressure: result held in RESP until rsp_ready; no requester is accepted outside IDLE.
// Ports: req_valid/req_ready/req_data per requester (operand i at [i*BIN_W +: BIN_W]);
//        rsp_valid/rsp_ready/rsp_id/rsp_bcd response; busy (state != IDLE);
//        conv_count saturating count of accepted responses.
module bcd_conv_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int BIN_W   = bcd_pkg::BIN_W,
    parameter int BCD_W   = bcd_pkg::BCD_W,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*BIN_W-1:0] req_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [BCD_W-1:0]         rsp_bcd,
    output logic                     busy,
    output logic [CNT_W-1:0]         conv_count
);

    import bcd_pkg::*;

    state_t             state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    id_q;
    logic [BIN_W-1:0]   op_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               rsp_valid_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [ID_W-1:0]    grant;
    logic [BIN_W-1:0]   grant_dat;
    logic [BCD_W-1:0]   conv_bcd;
    logic               any_vld;

    function automatic logic [ID_W-1:0] rr_pick(input logic [ID_W-1:0]    ptr,
                                                input logic [NUM_REQ-1:0] vld);
        return ID_W'(next_rr(3'(ptr), 8'(vld), NUM_REQ));
    endfunction

    assign any_vld = |req_valid;
    assign grant   = rr_pick(rr_ptr_q, req_valid);

    always_comb begin
        grant_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                grant_dat = req_data[i*BIN_W +: BIN_W];
            end
        end
    end

    // Ready is a function of valid only; gating with rst_n keeps it low while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == IDLE && any_vld) begin
            req_ready[grant] = 1'b1;
        end
    end

    binary_to_bcd u_conv (
        .binary_input (op_q),
        .bcd_output   (conv_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            op_q        <= '0;
            bcd_q       <= '0;
            rsp_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Any valid implies the granted ready is high, so this is the handshake.
                    if (any_vld) begin
                        op_q     <= grant_dat;
                        id_q     <= grant;
                        rr_ptr_q <= grant + 1'b1;   // power-of-two NUM_REQ wraps naturally
                        state_q  <= CONV;
                    end
                end
                CONV: begin
                    bcd_q       <= conv_bcd;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_bcd    = bcd_q;
    assign busy       = (state_q != IDLE);
    assign conv_count = cnt_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
module tb_bcd_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [19:0] req_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_bcd;
    logic        busy;
    logic [15:0] conv_count;

    // second instance with a 2-bit counter for saturation
    logic [3:0]  s_req_valid = '0;
    logic [3:0]  s_req_ready;
    logic [19:0] s_req_data = '0;
    logic        s_rsp_valid;
    logic        s_rsp_ready = 1'b1;
    logic [1:0]  s_rsp_id;
    logic [7:0]  s_rsp_bcd;
    logic        s_busy;
    logic [1:0]  s_conv_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bcd_conv_arbiter #(.NUM_REQ(4), .ID_W(2), .BIN_W(5), .BCD_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_bcd(rsp_bcd),
        .busy(busy), .conv_count(conv_count)
    );

    bcd_conv_arbiter #(.NUM_REQ(4), .ID_W(2), .BIN_W(5), .BCD_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_data(s_req_data),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id), .rsp_bcd(s_rsp_bcd),
        .busy(s_busy), .conv_count(s_conv_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int d);
        return (d / 10) * 16 + (d % 10);
    endfunction

    // ---------------- transaction-level reference model ----------------
    // One conversion outstanding at a time; a grant picks the first valid requester
    // after the previously granted one; the result is due two cycles after grant.
    bit          m_busy = 1'b0;
    int          m_ptr  = 0;
    int          m_due  = 0;
    int          m_id   = 0;
    int          m_bcd  = 0;
    logic [15:0] m_cnt  = '0;
    int          cyc    = 0;

    always @(negedge clk) begin
        int         g;
        int         idx;
        logic [3:0] exp_ready;
        bit         exp_rv;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_cnt  = '0;
            cyc    = 0;
            chk("rst_req_ready", 32'(req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_count", 32'(conv_count), 32'h0);
        end else begin
            g = -1;
            exp_ready = '0;
            if (!m_busy) begin
                for (int k = 0; k < 4; k++) begin
                    idx = (m_ptr + k) % 4;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            exp_rv = m_busy && (cyc >= m_due);
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("conv_count", 32'(conv_count), 32'(m_cnt));
            if (exp_rv) begin
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rsp_bcd", 32'(rsp_bcd), 32'(m_bcd));
            end
            if (g >= 0) begin
                m_busy = 1'b1;
                m_id   = g;
                m_bcd  = to_bcd(int'(req_data[g*5 +: 5]));
                m_due  = cyc + 2;
                m_ptr  = (g + 1) % 4;
            end else if (exp_rv && rsp_ready) begin
                m_busy = 1'b0;
                if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
            end
            cyc++;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_ready(input int idx, input string name);
        bit found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (req_ready[idx]) found = 1'b1;
        end
        if (!found) chk({name, "_ready_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic wait_rsp(input string name, output logic [1:0] id, output logic [7:0] bcd);
        bit found = 1'b0;
        id = '0;
        bcd = '0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                id = rsp_id;
                bcd = rsp_bcd;
                found = 1'b1;
            end
        end
        if (!found) chk({name, "_rsp_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic do_one(input int idx, input int val, output logic [1:0] id, output logic [7:0] bcd);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_data[idx*5 +: 5] = 5'(val);
        req_valid[idx] = 1'b1;
        wait_ready(idx, "one");
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        wait_rsp("one", id, bcd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  id;
        logic [7:0]  bcd;
        logic [1:0]  f_id[5];
        logic [7:0]  f_bcd[5];
        logic [1:0]  exp_ids[5];
        logic [7:0]  exp_bcds[5];
        logic [15:0] snap;
        logic [3:0]  hs;
        bit          found;

        exp_ids  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_bcds = '{8'h03, 8'h09, 8'h17, 8'h30, 8'h03};

        // reset with all requesters valid: ready must stay low
        #1 rst_n = 1'b0;
        req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_count", 32'(conv_count), 32'h0);
        chk("reset_sat_count", 32'(s_conv_count), 32'h0);
        req_valid = '0;
        rst_n = 1'b1;

        // single request on requester 1
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_data[5 +: 5] = 5'b10101;
        req_valid = 4'b0010;
        #1 chk("single_ready_same_cycle", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = '0;
        chk("single_conv_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("single_conv_busy", 32'(busy), 32'h1);
        @(posedge clk); #1;
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_id", 32'(rsp_id), 32'h1);
        chk("single_rsp_bcd", 32'(rsp_bcd), 32'h21);
        @(posedge clk); #1;
        chk("single_count", 32'(conv_count), 32'h1);
        chk("single_rsp_done", 32'(rsp_valid), 32'h0);

        // range sweep on requester 0
        for (int v = 0; v < 32; v++) begin
            do_one(0, v, id, bcd);
            chk("sweep_id", 32'(id), 32'h0);
            chk("sweep_bcd", 32'(bcd), 32'(to_bcd(v)));
            if (v == 0)  chk("sweep_zero", 32'(bcd), 32'h00);
            if (v == 31) chk("sweep_max", 32'(bcd), 32'h31);
        end

        // fairness from a fresh pointer
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        req_data = {5'd30, 5'd17, 5'd9, 5'd3};
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            wait_rsp("fair", f_id[n], f_bcd[n]);
        end
        @(posedge clk); #1 req_valid = '0;
        for (int n = 0; n < 5; n++) begin
            chk("fair_id", 32'(f_id[n]), 32'(exp_ids[n]));
            chk("fair_bcd", 32'(f_bcd[n]), 32'(exp_bcds[n]));
        end

        // backpressure: hold the response for 5 cycles
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_data[10 +: 5] = 5'd17;
        req_valid = 4'b0100;
        wait_ready(2, "bp");
        @(posedge clk); #1 req_valid = 4'b1011;
        wait_rsp("bp", id, bcd);
        snap = m_cnt;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_rsp_id", 32'(rsp_id), 32'h2);
            chk("bp_rsp_bcd", 32'(rsp_bcd), 32'h17);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_count_hold", 32'(conv_count), 32'(snap));
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        chk("bp_count_inc", 32'(conv_count), 32'(snap + 16'd1));
        chk("bp_rsp_cleared", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        chk("bp_count_once", 32'(conv_count), 32'(snap + 16'd1));

        // asynchronous reset while converting
        req_data[10 +: 5] = 5'd9;
        req_valid = 4'b0100;
        wait_ready(2, "rstmid");
        @(posedge clk); #1;
        req_valid = 4'b1111;
        chk("rstmid_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rstmid_busy", 32'(busy), 32'h0);
        chk("rstmid_count", 32'(conv_count), 32'h0);
        chk("rstmid_req_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1 chk("rstmid_first_grant", 32'(req_ready), 32'h1);
        @(posedge clk); #1 req_valid = '0;
        repeat (6) @(posedge clk);

        // counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            s_req_data[4:0] = 5'(i * 3);
            s_req_valid = 4'b0001;
            found = 1'b0;
            for (int k = 0; k < 40 && !found; k++) begin
                @(negedge clk);
                if (s_req_ready[0]) found = 1'b1;
            end
            if (!found) chk("sat_ready_timeout", 32'h0, 32'h1);
            @(posedge clk); #1 s_req_valid = '0;
            found = 1'b0;
            for (int k = 0; k < 40 && !found; k++) begin
                @(negedge clk);
                if (s_rsp_valid) found = 1'b1;
            end
            if (!found) chk("sat_rsp_timeout", 32'h0, 32'h1);
            chk("sat_bcd", 32'(s_rsp_bcd), 32'(to_bcd(i * 3)));
            @(posedge clk); #1;
            chk("sat_count", 32'(s_conv_count), 32'((i + 1 > 3) ? 3 : i + 1));
        end

        // randomized traffic, checked every cycle by the model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk); #2;
            hs = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (hs[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_data[i*5 +: 5] = 5'($urandom_range(0, 31));
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_valid[i] = 1'b1;
                        req_data[i*5 +: 5] = 5'($urandom_range(0, 31));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
